// File: rtl/rv_iopmp_pkg.sv
// rtl/rv_iopmp_pkg.sv - shared IOPMP types, table entries and error codes
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_READ      = 2'd0,
        ACCESS_WRITE     = 2'd1,
        ACCESS_EXECUTION = 2'd2
    } access_t;

    typedef struct packed {
        logic [62:0] md;
    } srcmd_entry_t;

    typedef struct packed {
        logic [15:0] t;
    } mdcfg_entry_t;

    localparam logic [2:0] ERR_ILLEGAL_READ  = 3'h1;
    localparam logic [2:0] ERR_ILLEGAL_WRITE = 3'h2;
    localparam logic [2:0] ERR_ILLEGAL_EXEC  = 3'h3;
    localparam logic [2:0] ERR_NOT_HIT       = 3'h5;
    localparam logic [2:0] ERR_UNKNOWN_SID   = 3'h6;

    function automatic logic [2:0] illegal_access_code(input access_t acc);
        case (acc)
            ACCESS_READ:  return ERR_ILLEGAL_READ;
            ACCESS_WRITE: return ERR_ILLEGAL_WRITE;
            default:      return ERR_ILLEGAL_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/rv_iopmp_dl_window_prio.sv
// rtl/rv_iopmp_dl_window_prio.sv - per-window eligibility mask and lowest-slot priority pick
module rv_iopmp_dl_window_prio
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_MDS             = 2,
    parameter int NUMBER_ENTRIES         = 16,
    parameter int NUMBER_ENTRY_ANALYZERS = 4,
    parameter int MODE                   = 0,
    parameter int SLOT_W                 = 2
) (
    input  logic [15:0]                       offset_i,
    input  logic [62:0]                       md_en_i,
    input  mdcfg_entry_t                      mdcfg_table_i [NUMBER_MDS],
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0] match_i,
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0] allow_i,
    output logic                              hit_o,
    output logic [SLOT_W-1:0]                 slot_o,
    output logic                              allow_o
);

    logic [NUMBER_ENTRY_ANALYZERS-1:0] elig;

    // An entry belongs to the first MD whose top lies above it; none means unreachable.
    function automatic logic entry_eligible(input logic [15:0] idx);
        logic found;
        logic on;
        found = 1'b0;
        on    = 1'b0;
        for (int m = 0; m < NUMBER_MDS; m++) begin
            if (!found && (idx < mdcfg_table_i[m].t)) begin
                found = 1'b1;
                on    = md_en_i[m];
            end
        end
        if (idx >= 16'(NUMBER_ENTRIES)) return 1'b0;
        if (MODE == 1) return 1'b1;
        return on;
    endfunction

    always_comb begin
        elig = '0;
        for (int s = 0; s < NUMBER_ENTRY_ANALYZERS; s++) begin
            elig[s] = entry_eligible(offset_i + 16'(s));
        end
    end

    always_comb begin
        hit_o   = 1'b0;
        slot_o  = '0;
        allow_o = 1'b0;
        for (int s = NUMBER_ENTRY_ANALYZERS - 1; s >= 0; s--) begin
            if (elig[s] && match_i[s]) begin
                hit_o   = 1'b1;
                slot_o  = SLOT_W'(s);
                allow_o = allow_i[s];
            end
        end
    end

endmodule

// File: rtl/rv_iopmp_dl_multipass.sv
// rtl/rv_iopmp_dl_multipass.sv - multi-cycle windowed IOPMP decision logic with early exit
module rv_iopmp_dl_multipass
    import rv_iopmp_pkg::*;
#(
    parameter int SID_WIDTH              = 8,
    parameter int NUMBER_MDS             = 2,
    parameter int NUMBER_ENTRIES         = 16,
    parameter int NUMBER_MASTERS         = 2,
    parameter int NUMBER_ENTRY_ANALYZERS = 4,
    parameter int MODE                   = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              enable_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [SID_WIDTH-1:0]              sid_i,
    input  access_t                           access_type_i,
    output logic [8:0]                        entry_offset_o,
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0] entry_match_i,
    input  logic [NUMBER_ENTRY_ANALYZERS-1:0] entry_allow_i,
    input  srcmd_entry_t                      srcmd_table_i [NUMBER_MASTERS],
    input  mdcfg_entry_t                      mdcfg_table_i [NUMBER_MDS],
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic                              allow_transaction_o,
    output logic                              err_transaction_o,
    output logic [2:0]                        err_type_o,
    output logic [15:0]                       err_entry_index_o
);

    localparam int NUM_WINDOWS = (NUMBER_ENTRIES + NUMBER_ENTRY_ANALYZERS - 1) / NUMBER_ENTRY_ANALYZERS;
    localparam int SLOT_W      = (NUMBER_ENTRY_ANALYZERS > 1) ? $clog2(NUMBER_ENTRY_ANALYZERS) : 1;
    localparam logic [9:0] LAST_W = 10'(NUM_WINDOWS - 1);
    localparam logic [SID_WIDTH:0] NM_W = (SID_WIDTH + 1)'(NUMBER_MASTERS);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic [9:0]             w_q, w_d;
    logic [15:0]            offset_q, offset_d;
    logic [SID_WIDTH-1:0]   sid_q, sid_d;
    access_t                acc_q, acc_d;
    logic                   allow_q, allow_d;
    logic                   err_q, err_d;
    logic [2:0]             type_q, type_d;
    logic [15:0]            index_q, index_d;

    logic [62:0]            md_en;
    logic                   win_hit;
    logic [SLOT_W-1:0]      win_slot;
    logic                   win_allow;

    // Out-of-range SIDs never reach SCAN in MODE 0, so no entry enables them here.
    always_comb begin
        md_en = '0;
        for (int i = 0; i < NUMBER_MASTERS; i++) begin
            if (sid_q == SID_WIDTH'(i)) md_en = srcmd_table_i[i].md;
        end
    end

    rv_iopmp_dl_window_prio #(
        .NUMBER_MDS             (NUMBER_MDS),
        .NUMBER_ENTRIES         (NUMBER_ENTRIES),
        .NUMBER_ENTRY_ANALYZERS (NUMBER_ENTRY_ANALYZERS),
        .MODE                   (MODE),
        .SLOT_W                 (SLOT_W)
    ) u_window_prio (
        .offset_i      (offset_q),
        .md_en_i       (md_en),
        .mdcfg_table_i (mdcfg_table_i),
        .match_i       (entry_match_i),
        .allow_i       (entry_allow_i),
        .hit_o         (win_hit),
        .slot_o        (win_slot),
        .allow_o       (win_allow)
    );

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        offset_d = offset_q;
        sid_d    = sid_q;
        acc_d    = acc_q;
        allow_d  = allow_q;
        err_d    = err_q;
        type_d   = type_q;
        index_d  = index_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    sid_d    = sid_i;
                    acc_d    = access_type_i;
                    w_d      = '0;
                    offset_d = '0;
                    allow_d  = 1'b0;
                    err_d    = 1'b0;
                    type_d   = '0;
                    index_d  = '0;
                    if (!enable_i) begin
                        allow_d = 1'b1;
                        state_d = ST_RESP;
                    end else if ((MODE == 0) && ({1'b0, sid_i} >= NM_W)) begin
                        err_d   = 1'b1;
                        type_d  = ERR_UNKNOWN_SID;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (win_hit) begin
                    allow_d = win_allow;
                    err_d   = !win_allow;
                    type_d  = win_allow ? 3'h0 : illegal_access_code(acc_q);
                    index_d = offset_q + 16'(win_slot);
                    state_d = ST_RESP;
                end else if (w_q == LAST_W) begin
                    err_d   = 1'b1;
                    type_d  = ERR_NOT_HIT;
                    state_d = ST_RESP;
                end else begin
                    w_d      = w_q + 10'd1;
                    offset_d = offset_q + 16'(NUMBER_ENTRY_ANALYZERS);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            w_q      <= '0;
            offset_q <= '0;
            sid_q    <= '0;
            acc_q    <= ACCESS_READ;
            allow_q  <= 1'b0;
            err_q    <= 1'b0;
            type_q   <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            offset_q <= offset_d;
            sid_q    <= sid_d;
            acc_q    <= acc_d;
            allow_q  <= allow_d;
            err_q    <= err_d;
            type_q   <= type_d;
            index_q  <= index_d;
        end
    end

    assign req_ready_o         = (state_q == ST_IDLE);
    assign resp_valid_o        = (state_q == ST_RESP);
    assign entry_offset_o      = offset_q[8:0];
    assign allow_transaction_o = allow_q;
    assign err_transaction_o   = err_q;
    assign err_type_o          = type_q;
    assign err_entry_index_o   = index_q;

endmodule

// File: tb/tb_rv_iopmp_dl_multipass.sv
// tb/tb_rv_iopmp_dl_multipass.sv - scoreboard bench for two configurations of the multipass decision logic
module tb_rv_iopmp_dl_multipass;
    import rv_iopmp_pkg::*;

    localparam int NA = 4;

    typedef struct {
        bit allow;
        bit err;
        int typ;
        int idx;
        int lat;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        enable     [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [7:0]  sid        [2];
    access_t     acc        [2];
    logic [8:0]  offset     [2];
    logic [3:0]  ematch     [2];
    logic [3:0]  eallow     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic        allow      [2];
    logic        err        [2];
    logic [2:0]  etype      [2];
    logic [15:0] eidx       [2];

    srcmd_entry_t srcmd [2];
    mdcfg_entry_t mdcfg [2];
    bit mt [2][16];
    bit al [2][16];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ematch[d] = '0;
            eallow[d] = '0;
            for (int s = 0; s < NA; s++) begin
                if (int'(offset[d]) + s < 16) begin
                    ematch[d][s] = mt[d][int'(offset[d]) + s];
                    eallow[d][s] = al[d][int'(offset[d]) + s];
                end
            end
        end
    end

    rv_iopmp_dl_multipass #(.MODE(0), .NUMBER_ENTRIES(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .sid_i(sid[0]), .access_type_i(acc[0]), .entry_offset_o(offset[0]),
        .entry_match_i(ematch[0]), .entry_allow_i(eallow[0]),
        .srcmd_table_i(srcmd), .mdcfg_table_i(mdcfg),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .allow_transaction_o(allow[0]), .err_transaction_o(err[0]),
        .err_type_o(etype[0]), .err_entry_index_o(eidx[0])
    );

    rv_iopmp_dl_multipass #(.MODE(1), .NUMBER_ENTRIES(10)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .sid_i(sid[1]), .access_type_i(acc[1]), .entry_offset_o(offset[1]),
        .entry_match_i(ematch[1]), .entry_allow_i(eallow[1]),
        .srcmd_table_i(srcmd), .mdcfg_table_i(mdcfg),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .allow_transaction_o(allow[1]), .err_transaction_o(err[1]),
        .err_type_o(etype[1]), .err_entry_index_o(eidx[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    exp_t q0[$];
    exp_t q1[$];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void qflush(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endfunction

    // Reference: walk the entry list in index order; latency follows from the hit's window.
    function automatic exp_t model(input int d, input bit en, input int s, input int a);
        exp_t e;
        int ne;
        ne = (d == 0) ? 16 : 10;
        e = '{allow: 1'b0, err: 1'b0, typ: 0, idx: 0, lat: 0, acc_cyc: 0};
        if (!en) begin
            e.allow = 1'b1;
            e.lat   = 1;
            return e;
        end
        if (d == 0 && s >= 2) begin
            e.err = 1'b1;
            e.typ = 6;
            e.lat = 1;
            return e;
        end
        for (int i = 0; i < ne; i++) begin
            bit elig;
            int mdi;
            elig = (d == 1);
            if (d == 0) begin
                mdi = -1;
                for (int m = 0; m < 2; m++)
                    if (mdi < 0 && i < int'(mdcfg[m].t)) mdi = m;
                elig = (mdi >= 0) && srcmd[s].md[mdi];
            end
            if (elig && mt[d][i]) begin
                e.allow = al[d][i];
                e.err   = !al[d][i];
                e.typ   = al[d][i] ? 0 : a + 1;
                e.idx   = i;
                e.lat   = i / NA + 2;
                return e;
            end
        end
        e.err = 1'b1;
        e.typ = 5;
        e.lat = (ne + NA - 1) / NA + 1;
        return e;
    endfunction

    task automatic check_fields(input int d, input string tag, input exp_t e);
        chk($sformatf("d%0d %s allow", d, tag), int'(allow[d]), int'(e.allow));
        chk($sformatf("d%0d %s err", d, tag), int'(err[d]), int'(e.err));
        chk($sformatf("d%0d %s type", d, tag), int'(etype[d]), e.typ);
        chk($sformatf("d%0d %s index", d, tag), int'(eidx[d]), e.idx);
    endtask

    task automatic monitor(input int d);
        exp_t e;
        bit pv;
        bit phs;
        bit have;
        pv = 1'b0; phs = 1'b0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0; phs = 1'b0; have = 1'b0;
            end else begin
                if (phs) chk($sformatf("d%0d valid_after_handshake", d), int'(resp_valid[d]), 0);
                if (resp_valid[d] === 1'b1 && !pv) begin
                    if (qsize(d) == 0) begin
                        chk($sformatf("d%0d unexpected_resp", d), int'(resp_valid[d]), 0);
                        have = 1'b0;
                    end else begin
                        e = qpop(d);
                        have = 1'b1;
                        check_fields(d, "resp", e);
                        chk($sformatf("d%0d latency", d), cyc - e.acc_cyc, e.lat);
                    end
                end else if (resp_valid[d] === 1'b1 && have) begin
                    check_fields(d, "hold", e);
                end
                phs = (resp_valid[d] === 1'b1) && (resp_ready[d] === 1'b1);
                pv  = (resp_valid[d] === 1'b1);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic issue(input int d, input bit en, input int s, input int a, input int hold);
        exp_t e;
        int t;
        @(negedge clk);
        t = 0;
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        e = model(d, en, s, a);
        e.acc_cyc = cyc;
        enable[d]    = en;
        sid[d]       = 8'(s);
        acc[d]       = access_t'(a);
        req_valid[d] = 1'b1;
        qpush(d, e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int c = 1; c < e.lat; c++) begin
            chk($sformatf("d%0d offset c%0d", d, c), int'(offset[d]), (c - 1) * NA);
            if (c < e.lat - 1) @(negedge clk);
        end
        t = 0;
        while (resp_valid[d] !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (resp_valid[d] !== 1'b1) begin
            chk($sformatf("d%0d resp_timeout", d), int'(resp_valid[d]), 1);
            qflush(d);
        end else begin
            for (int h = 0; h < hold; h++) @(negedge clk);
            resp_ready[d] = 1'b1;
            @(negedge clk);
            resp_ready[d] = 1'b0;
            chk($sformatf("d%0d idle_after_resp", d), int'(req_ready[d]), 1);
        end
    endtask

    task automatic clear_entries(input int d);
        for (int i = 0; i < 16; i++) begin
            mt[d][i] = 1'b0;
            al[d][i] = 1'b0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            enable[d] = 1'b1; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
            sid[d] = '0; acc[d] = ACCESS_READ;
            clear_entries(d);
        end
        srcmd[0].md = 63'd0;
        srcmd[1].md = 63'd3;
        mdcfg[0].t  = 16'd8;
        mdcfg[1].t  = 16'd16;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst req_ready", d), int'(req_ready[d]), 1);
            chk($sformatf("d%0d rst resp_valid", d), int'(resp_valid[d]), 0);
            chk($sformatf("d%0d rst allow", d), int'(allow[d]), 0);
            chk($sformatf("d%0d rst err", d), int'(err[d]), 0);
            chk($sformatf("d%0d rst type", d), int'(etype[d]), 0);
            chk($sformatf("d%0d rst index", d), int'(eidx[d]), 0);
            chk($sformatf("d%0d rst offset", d), int'(offset[d]), 0);
        end
        rst_n = 1'b1;

        mt[0][9] = 1'b1; al[0][9] = 1'b1;
        issue(0, 1'b1, 1, 0, 0);
        al[0][9] = 1'b0;
        issue(0, 1'b1, 1, 1, 1);
        mt[0][9] = 1'b0;
        mt[0][2] = 1'b1; al[0][2] = 1'b1;
        mt[0][10] = 1'b1; al[0][10] = 1'b1;
        srcmd[0].md = 63'd2;
        issue(0, 1'b1, 0, 2, 0);
        clear_entries(0);
        issue(0, 1'b1, 1, 0, 3);
        issue(0, 1'b1, 5, 0, 0);
        issue(0, 1'b0, 1, 1, 0);

        mt[1][10] = 1'b1; mt[1][11] = 1'b1; al[1][10] = 1'b1; al[1][11] = 1'b1;
        issue(1, 1'b1, 0, 0, 0);
        mt[1][7] = 1'b1;
        issue(1, 1'b1, 200, 2, 1);

        // Reset during SCAN must abort silently.
        clear_entries(1);
        @(negedge clk);
        enable[1] = 1'b1; req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("d1 midscan_rst resp_valid", int'(resp_valid[1]), 0);
        chk("d1 midscan_rst req_ready", int'(req_ready[1]), 1);
        chk("d1 midscan_rst offset", int'(offset[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("d1 no_resp_after_rst", int'(resp_valid[1]), 0);

        for (int n = 0; n < 60; n++) begin
            int d;
            d = n % 2;
            clear_entries(d);
            for (int i = 0; i < 16; i++) begin
                mt[d][i] = ($urandom_range(0, 5) == 0);
                al[d][i] = $urandom_range(0, 1) != 0;
            end
            srcmd[0].md = 63'($urandom_range(0, 3));
            srcmd[1].md = 63'($urandom_range(0, 3));
            mdcfg[0].t  = 16'($urandom_range(0, 16));
            mdcfg[1].t  = 16'($urandom_range(int'(mdcfg[0].t), 16));
            issue(d, $urandom_range(0, 7) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        chk("d0 queue_drained", qsize(0), 0);
        chk("d1 queue_drained", qsize(1), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
